vld_beat_packer: RTL

//  Upstream feeder of the vector load unit. Accepts fixed-width memory response beats from
//  the scalar core's load port and packs them into vrf_data_t words for the VLU load-operand

---
 rtl/vld_beat_packer_pkg.sv | 34 +++
 rtl/vld_beat_packer_if.sv | 40 ++++
 rtl/vld_beat_packer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vld_beat_packer_pkg.sv
// Shared types and sizing for the vector-load beat packer.
// Word geometry comes from vrf_data_t; NrLane words form one ByteBlock.
package vld_beat_packer_pkg;

  localparam int unsigned NrLane  = 4;
  localparam int unsigned VlenW   = 16;
  localparam int unsigned InsnIdW = 4;

  typedef logic [63:0]        vrf_data_t;
  typedef logic [VlenW-1:0]   vlen_t;
  typedef logic [InsnIdW-1:0] insn_id_t;

  // One extra bit so ceil() of the largest length cannot wrap.
  typedef logic [VlenW:0]     vcnt_t;

  localparam int unsigned WordBytes    = $bits(vrf_data_t) / 8;
  localparam int unsigned ByteBlock    = NrLane * WordBytes;
  localparam int unsigned DefBeatBytes = 4;
  localparam int unsigned BeatsPerWord = WordBytes / DefBeatBytes;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PAD,
    DONE
  } packer_state_e;

  function automatic vcnt_t ceil_div(vlen_t a, int unsigned b);
    vcnt_t num;
    num = {1'b0, a} + vcnt_t'(b - 1);
    return num / vcnt_t'(b);
  endfunction

endpackage

// File: rtl/vld_beat_packer_if.sv
// Command, memory-response, load-operand and completion signals of the beat packer.
// slave is the packer side, master is the environment driving it.
interface vld_beat_packer_if #(
  parameter int unsigned BeatBytes = vld_beat_packer_pkg::DefBeatBytes
);
  import vld_beat_packer_pkg::*;

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  vlen_t                  cmd_vlB_i;
  insn_id_t               cmd_id_i;
  logic                   mem_rvalid_i;
  logic                   mem_rready_o;
  logic [BeatBytes*8-1:0] mem_rdata_i;
  logic                   mem_rerr_i;
  logic                   load_op_valid_o;
  logic                   load_op_ready_i;
  vrf_data_t              load_op_o;
  logic                   done_o;
  logic                   done_gnt_i;
  insn_id_t               done_id_o;
  logic                   done_err_o;

  modport slave (
    input  cmd_valid_i, cmd_vlB_i, cmd_id_i,
    input  mem_rvalid_i, mem_rdata_i, mem_rerr_i,
    input  load_op_ready_i, done_gnt_i,
    output cmd_ready_o, mem_rready_o, load_op_valid_o, load_op_o,
    output done_o, done_id_o, done_err_o
  );

  modport master (
    output cmd_valid_i, cmd_vlB_i, cmd_id_i,
    output mem_rvalid_i, mem_rdata_i, mem_rerr_i,
    output load_op_ready_i, done_gnt_i,
    input  cmd_ready_o, mem_rready_o, load_op_valid_o, load_op_o,
    input  done_o, done_id_o, done_err_o
  );

endinterface

// File: rtl/vld_beat_packer.sv
// Packs memory beats into vrf_data_t words and pads each instruction to a whole ByteBlock.
// Define VLD_PACKER_ZERO_FILL_EN to zero the bytes past vlB and the pad words.
module vld_beat_packer
  import vld_beat_packer_pkg::*;
#(
  parameter int unsigned BeatBytes = DefBeatBytes
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  vld_beat_packer_if.slave bus
);

  localparam int unsigned BeatW = BeatBytes * 8;
  localparam int unsigned Bpw   = WordBytes / BeatBytes;
  localparam int unsigned IdxW  = (Bpw > 1) ? $clog2(Bpw) : 1;
  localparam int unsigned PadW  = (NrLane > 1) ? $clog2(NrLane) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PadW-1:0] pad_t;

  packer_state_e    state_q, state_d;
  vcnt_t            beats_left_q, beats_left_d;
  pad_t             pad_left_q, pad_left_d;
  idx_t             beat_idx_q, beat_idx_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  vrf_data_t        asm_q, asm_d;
  insn_id_t         id_q, id_d;
  vcnt_t            words;
  logic [BeatW-1:0] beat_data;
  logic             mem_rready, beat_hs, word_hs, last_beat;

`ifdef VLD_PACKER_ZERO_FILL_EN
  localparam int unsigned OffW = (BeatBytes > 1) ? $clog2(BeatBytes) : 1;
  logic [OffW-1:0] tail_q, tail_d;
`endif

  // A new beat may land in the same cycle the held word is taken.
  assign mem_rready = (state_q == FILL) && (beats_left_q != '0) &&
                      (!valid_q || bus.load_op_ready_i);
  assign beat_hs    = mem_rready && bus.mem_rvalid_i;
  assign word_hs    = valid_q && bus.load_op_ready_i;
  assign last_beat  = (beats_left_q == vcnt_t'(1));

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    pad_left_d   = pad_left_q;
    beat_idx_d   = beat_idx_q;
    valid_d      = valid_q;
    err_d        = err_q;
    asm_d        = asm_q;
    id_d         = id_q;
    words        = ceil_div(bus.cmd_vlB_i, WordBytes);
    beat_data    = bus.mem_rdata_i;
`ifdef VLD_PACKER_ZERO_FILL_EN
    tail_d = tail_q;
    for (int b = 0; b < int'(BeatBytes); b++) begin
      if (last_beat && (tail_q != '0) && (b >= int'(tail_q))) begin
        beat_data[b*8 +: 8] = 8'h00;
      end
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          id_d         = bus.cmd_id_i;
          err_d        = 1'b0;
          beat_idx_d   = '0;
          beats_left_d = ceil_div(bus.cmd_vlB_i, BeatBytes);
          pad_left_d   = pad_t'((vcnt_t'(NrLane) - (words % vcnt_t'(NrLane))) % vcnt_t'(NrLane));
`ifdef VLD_PACKER_ZERO_FILL_EN
          tail_d       = OffW'(bus.cmd_vlB_i % vlen_t'(BeatBytes));
`endif
          state_d      = (bus.cmd_vlB_i == '0) ? DONE : FILL;
        end
      end

      FILL: begin
        if (word_hs) begin
          valid_d = 1'b0;
        end
        if (beat_hs) begin
`ifdef VLD_PACKER_ZERO_FILL_EN
          if (beat_idx_q == '0) begin
            asm_d = '0;
          end
`endif
          for (int b = 0; b < int'(Bpw); b++) begin
            if (beat_idx_q == idx_t'(b)) begin
              asm_d[b*BeatW +: BeatW] = beat_data;
            end
          end
          beats_left_d = beats_left_q - vcnt_t'(1);
          err_d        = err_q | bus.mem_rerr_i;
          if ((beat_idx_q == idx_t'(Bpw - 1)) || last_beat) begin
            beat_idx_d = '0;
            valid_d    = 1'b1;
          end else begin
            beat_idx_d = beat_idx_q + idx_t'(1);
          end
        end else if (word_hs && (beats_left_q == '0)) begin
          // Final data word just left; either pad out the ByteBlock or finish.
          if (pad_left_q != '0) begin
            state_d = PAD;
            valid_d = 1'b1;
`ifdef VLD_PACKER_ZERO_FILL_EN
            asm_d   = '0;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end

      PAD: begin
        if (word_hs) begin
          pad_left_d = pad_left_q - pad_t'(1);
          if (pad_left_q == pad_t'(1)) begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (bus.done_gnt_i) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      pad_left_q   <= '0;
      beat_idx_q   <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      pad_left_q   <= pad_left_d;
      beat_idx_q   <= beat_idx_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  // Data-path registers carry no reset; valid_q qualifies them.
  always_ff @(posedge clk_i) begin
    asm_q <= asm_d;
    id_q  <= id_d;
`ifdef VLD_PACKER_ZERO_FILL_EN
    tail_q <= tail_d;
`endif
  end

  assign bus.cmd_ready_o     = (state_q == IDLE);
  assign bus.mem_rready_o    = mem_rready;
  assign bus.load_op_valid_o = valid_q;
  assign bus.load_op_o       = asm_q;
  assign bus.done_o          = (state_q == DONE);
  assign bus.done_id_o       = id_q;
  assign bus.done_err_o      = err_q;

endmodule
